robo_ctrl: RTL and testbench
============================

# robo_ctrl

Maze-robot controller that drives the maze/environment model from the sensor side. It reads the four sensor flags (head, left, under, barrier), runs a left-hand wall-following state machine and issues one-hot `avancar`/`girar`/`remover` commands back to the environment. It stops when the robot stands on a black cell. It is the decision-making counterpart of the map model and is wired port-to-port with it in the system top.

## Interface
Parameters:
- REMOVE_MAX, 15: maximum consecutive `remover` cycles before the barrier is abandoned.
- STEP_W, 16: width of the step counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; sampled on `clock` rising edge.
- head_in  in  1  1 = wall or map edge straight ahead.
- left_in  in  1  1 = wall or map edge on the robot's left.
- under_in  in  1  1 = current cell is black (goal).
- barrier_in  in  1  1 = barrier (any strength) straight ahead.
- avancar  out  1  move one cell forward.
- girar  out  1  rotate 90° counter-clockwise (left).
- remover  out  1  hammer the barrier ahead; held continuously.
- done  out  1  goal reached; sticky.
- steps  out  STEP_W  forward moves issued.

## Operation
- All outputs are registered. At most one of avancar/girar/remover is high in any cycle.
- Reset values: avancar=0, girar=0, remover=0, done=0, steps=0. State is SENSE, `turned_left`=0, `turn_cnt`=0, `rem_cnt`=0.
- States: SENSE, CMD, WAIT, REMOVE, DONE.
- SENSE evaluates these rules in priority order:
  1. under_in=1 → DONE.
  2. left_in=0 and turned_left=0 → pulse girar, set turned_left.
  3. barrier_in=1 → REMOVE.
  4. head_in=0 → pulse avancar, clear turned_left, increment steps.
  5. Otherwise → right turn: pulse girar with turn_cnt=2. Clear turned_left.
- Each of rules 2, 4 and 5 loads the command and goes to CMD.
- CMD drives the command for exactly one cycle, then goes to WAIT.
- WAIT drives no command for one cycle. If turn_cnt≠0, decrement turn_cnt and go back to CMD with girar. Otherwise go to SENSE.
- A right turn is therefore three girar pulses, each followed by a WAIT cycle. Sensors are not examined until all three are done.
- REMOVE:
  - remover is held high and rem_cnt increments every cycle.
  - barrier_in=0 sampled → deassert remover, go to WAIT, rem_cnt=0.
  - rem_cnt reaches REMOVE_MAX → deassert remover, start a right turn, rem_cnt=0.
  - One trailing remover cycle after the barrier clears is permitted.
- DONE: all commands 0, done=1. Leave only by reset.
- steps saturates at all-ones and does not wrap.
- Reset asserted in any state, including mid-REMOVE or mid-right-turn: next cycle, all outputs are at their reset values.

## Timing
- Inputs are treated as combinational from the environment state and are sampled only in SENSE and REMOVE.
- Turn or forward move:
  - Cycle t: SENSE.
  - Cycle t+1: command high.
  - Cycle t+2: WAIT.
  - Cycle t+3: SENSE.
  - One action therefore takes 3 cycles.
- Right turn: 7 cycles from SENSE to the next SENSE (CMD, WAIT ×3).
- done rises the cycle after a SENSE in which under_in=1.
- Barrier of strength 9 (3 decrements × 3 cycles): remover is high for at least 9 cycles and at most 10, within the default REMOVE_MAX.

## Configuration
- `ROBO_STEP_COUNT_EN` defined: steps counts forward moves as specified.
- `ROBO_STEP_COUNT_EN` undefined: the counter is not built and steps is tied to 0. The port list is unchanged.

## Structure
- Shared package `robo_pkg`:
  - state encoding (SENSE, CMD, WAIT, REMOVE, DONE);
  - command one-hot constants;
  - orientation encoding NORTH=0, WEST=1, SOUTH=2, EAST=3, shared with the map model.
- Single module, no sub-modules.
- The saturating counter is inline logic, guarded by the macro.

## Test plan
- Reset mid-REMOVE: reset for 1 cycle → next cycle remover=0, steps=0, state SENSE.
- Open left: inputs left=0, head=0, barrier=0, under=0 → girar pulse at t+1, then the next SENSE issues avancar regardless of left. steps=1.
- Dead end: inputs head=1, left=1, barrier=0 → exactly three girar pulses at cycles t+1, t+3 and t+5, no avancar. Next SENSE at t+7.
- Barrier 9, using the paired environment model: remover high for 9–10 consecutive cycles, then barrier_in falls, WAIT, SENSE, avancar. steps increments by 1.
- Stuck barrier: barrier_in held at 1 → remover high for exactly 15 cycles, then the right-turn sequence starts.
- Goal: under_in=1 at SENSE → done=1 from the next cycle onward and no further commands. Step saturation with STEP_W=4: after 20 moves, steps stays at 15.

Source files
------------

// File: rtl/robo_pkg.sv
// rtl/robo_pkg.sv - shared encodings for the maze-robot controller and map model
package robo_pkg;

   typedef enum logic [2:0] {
      ST_SENSE,
      ST_CMD,
      ST_WAIT,
      ST_REMOVE,
      ST_DONE
   } state_e;

   // Command vector bit order: {avancar, girar, remover}
   localparam logic [2:0] CMD_NONE    = 3'b000;
   localparam logic [2:0] CMD_AVANCAR = 3'b100;
   localparam logic [2:0] CMD_GIRAR   = 3'b010;
   localparam logic [2:0] CMD_REMOVER = 3'b001;

   typedef enum logic [1:0] {
      NORTH = 2'd0,
      WEST  = 2'd1,
      SOUTH = 2'd2,
      EAST  = 2'd3
   } orient_e;

endpackage

// File: rtl/robo_ctrl.sv
// rtl/robo_ctrl.sv - left-hand wall-following controller; ROBO_STEP_COUNT_EN builds the step counter
import robo_pkg::*;

module robo_ctrl #(
   parameter int REMOVE_MAX = 15,
   parameter int STEP_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              head_in,
   input  logic              left_in,
   input  logic              under_in,
   input  logic              barrier_in,
   output logic              avancar,
   output logic              girar,
   output logic              remover,
   output logic              done,
   output logic [STEP_W-1:0] steps
);

   localparam int              REM_W    = $clog2(REMOVE_MAX + 1);
   localparam logic [REM_W-1:0] REM_LAST = REM_W'(REMOVE_MAX);

   state_e           state_q, state_d;
   logic [2:0]       cmd_q, cmd_d;
   logic             done_q, done_d;
   logic             turned_left_q, turned_left_d;
   logic [1:0]       turn_cnt_q, turn_cnt_d;
   logic [REM_W-1:0] rem_cnt_q, rem_cnt_d;
`ifdef ROBO_STEP_COUNT_EN
   logic [STEP_W-1:0] steps_q, steps_d;
`endif

   always_comb begin
      state_d       = state_q;
      cmd_d         = CMD_NONE;
      done_d        = done_q;
      turned_left_d = turned_left_q;
      turn_cnt_d    = turn_cnt_q;
      rem_cnt_d     = rem_cnt_q;
`ifdef ROBO_STEP_COUNT_EN
      steps_d       = steps_q;
`endif
      case (state_q)
         ST_SENSE: begin
            if (under_in) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (!left_in && !turned_left_q) begin
               cmd_d         = CMD_GIRAR;
               turned_left_d = 1'b1;
               state_d       = ST_CMD;
            end else if (barrier_in) begin
               cmd_d     = CMD_REMOVER;
               rem_cnt_d = REM_W'(1);
               state_d   = ST_REMOVE;
            end else if (!head_in) begin
               cmd_d         = CMD_AVANCAR;
               turned_left_d = 1'b0;
               state_d       = ST_CMD;
`ifdef ROBO_STEP_COUNT_EN
               if (steps_q != '1) steps_d = steps_q + 1'b1;
`endif
            end else begin
               // Right turn = three left turns; two more queued in turn_cnt
               cmd_d         = CMD_GIRAR;
               turn_cnt_d    = 2'd2;
               turned_left_d = 1'b0;
               state_d       = ST_CMD;
            end
         end
         ST_CMD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (turn_cnt_q != 2'd0) begin
               turn_cnt_d = turn_cnt_q - 2'd1;
               cmd_d      = CMD_GIRAR;
               state_d    = ST_CMD;
            end else begin
               state_d = ST_SENSE;
            end
         end
         ST_REMOVE: begin
            if (!barrier_in) begin
               rem_cnt_d = '0;
               state_d   = ST_WAIT;
            end else if (rem_cnt_q == REM_LAST) begin
               rem_cnt_d     = '0;
               cmd_d         = CMD_GIRAR;
               turn_cnt_d    = 2'd2;
               turned_left_d = 1'b0;
               state_d       = ST_CMD;
            end else begin
               rem_cnt_d = rem_cnt_q + 1'b1;
               cmd_d     = CMD_REMOVER;
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_SENSE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_SENSE;
         cmd_q         <= CMD_NONE;
         done_q        <= 1'b0;
         turned_left_q <= 1'b0;
         turn_cnt_q    <= 2'd0;
         rem_cnt_q     <= '0;
`ifdef ROBO_STEP_COUNT_EN
         steps_q       <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         done_q        <= done_d;
         turned_left_q <= turned_left_d;
         turn_cnt_q    <= turn_cnt_d;
         rem_cnt_q     <= rem_cnt_d;
`ifdef ROBO_STEP_COUNT_EN
         steps_q       <= steps_d;
`endif
      end
   end

   assign avancar = cmd_q[2];
   assign girar   = cmd_q[1];
   assign remover = cmd_q[0];
   assign done    = done_q;
`ifdef ROBO_STEP_COUNT_EN
   assign steps   = steps_q;
`else
   assign steps   = '0;
`endif

endmodule

// File: tb/tb_robo_ctrl.sv
// tb/tb_robo_ctrl.sv - scoreboard bench for robo_ctrl (STEP_W=4); honours ROBO_STEP_COUNT_EN
module tb_robo_ctrl;

   localparam logic [3:0] DN = 4'b1000;
   localparam logic [3:0] AV = 4'b0100;
   localparam logic [3:0] GI = 4'b0010;
   localparam logic [3:0] RM = 4'b0001;
`ifdef ROBO_STEP_COUNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       head_in = 1'b0, left_in = 1'b1, under_in = 1'b0, barrier_in = 1'b0;
   logic       avancar, girar, remover, done;
   logic [3:0] steps;

   robo_ctrl #(.REMOVE_MAX(15), .STEP_W(4)) dut (
      .clock(clock), .reset(reset),
      .head_in(head_in), .left_in(left_in), .under_in(under_in), .barrier_in(barrier_in),
      .avancar(avancar), .girar(girar), .remover(remover), .done(done), .steps(steps)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] code;
      int         at;
      int         steps;
   } exp_t;
   exp_t sb[$];

   int   vectors = 0;
   int   miscompares = 0;
   logic done_prev = 1'b0;

   function automatic int exp_steps(input int n);
      if (!CNT_ON) return 0;
      return (n > 15) ? 15 : n;
   endfunction

   always @(negedge clock) begin
      logic [3:0] act;
      exp_t       e;
      act = {done & ~done_prev, avancar, girar, remover};
      done_prev = done;
      if (act != 4'b0000) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output cyc=%0d got=%b steps=%0d expected=none", cyc, act, steps);
         end else begin
            e = sb.pop_front();
            if (act !== e.code || cyc != e.at || int'(steps) != e.steps) begin
               miscompares++;
               $display("FAIL output_event got code=%b cyc=%0d steps=%0d expected code=%b cyc=%0d steps=%0d",
                        act, cyc, steps, e.code, e.at, e.steps);
            end
         end
      end
   end

   task automatic push(input logic [3:0] code, input int at, input int st);
      exp_t e;
      e.code = code; e.at = at; e.steps = st;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   task automatic do_reset(output int c);
      reset = 1'b1;
      @(negedge clock);
      check("rst_avancar", int'(avancar), 0);
      check("rst_girar", int'(girar), 0);
      check("rst_remover", int'(remover), 0);
      check("rst_done", int'(done), 0);
      check("rst_steps", int'(steps), 0);
      reset = 1'b0;
      c = cyc;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      repeat (4) @(negedge clock);
      check(name, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int c, c2, rem_seen;
      @(negedge clock);

      // Open left: turn left, then advance regardless of left
      do_reset(c);
      left_in = 1'b0; head_in = 1'b0; barrier_in = 1'b0; under_in = 1'b0;
      push(GI, c + 1, 0);
      push(AV, c + 4, exp_steps(1));
      wait_until(c + 4);
      under_in = 1'b1;
      push(DN, c + 7, exp_steps(1));
      drain("open_left");

      // Dead end: three girar pulses, next SENSE at t+7
      do_reset(c);
      head_in = 1'b1; left_in = 1'b1; barrier_in = 1'b0; under_in = 1'b0;
      push(GI, c + 1, 0); push(GI, c + 3, 0); push(GI, c + 5, 0);
      wait_until(c + 2);
      under_in = 1'b1;
      push(DN, c + 8, 0);
      drain("dead_end");

      // Barrier of strength 9 cleared by the environment after 9 hits
      do_reset(c);
      head_in = 1'b0; left_in = 1'b1; barrier_in = 1'b1; under_in = 1'b0;
      rem_seen = 0;
      for (int k = 1; k <= 9; k++) push(RM, c + k, 0);
      push(AV, c + 12, exp_steps(1));
      while (cyc < c + 12) begin
         @(negedge clock);
         if (remover) rem_seen++;
         barrier_in = (rem_seen < 9);
      end
      under_in = 1'b1;
      push(DN, c + 15, exp_steps(1));
      drain("barrier9");

      // Stuck barrier: 15 remover cycles then a right turn
      do_reset(c);
      head_in = 1'b1; left_in = 1'b1; barrier_in = 1'b1; under_in = 1'b0;
      for (int k = 1; k <= 15; k++) push(RM, c + k, 0);
      push(GI, c + 16, 0); push(GI, c + 18, 0); push(GI, c + 20, 0);
      wait_until(c + 16);
      under_in = 1'b1;
      push(DN, c + 23, 0);
      drain("stuck_barrier");

      // Reset in the middle of REMOVE, then a fresh SENSE advances
      do_reset(c);
      head_in = 1'b1; left_in = 1'b1; barrier_in = 1'b1; under_in = 1'b0;
      for (int k = 1; k <= 5; k++) push(RM, c + k, 0);
      wait_until(c + 5);
      do_reset(c2);
      check("mid_remove_reset_cycle", c2, c + 6);
      head_in = 1'b0; left_in = 1'b1; barrier_in = 1'b0; under_in = 1'b0;
      push(AV, c2 + 1, exp_steps(1));
      wait_until(c2 + 1);
      under_in = 1'b1;
      push(DN, c2 + 4, exp_steps(1));
      drain("reset_mid_remove");

      // Goal: done sticky, sensors ignored afterwards
      do_reset(c);
      head_in = 1'b0; left_in = 1'b1; barrier_in = 1'b0; under_in = 1'b1;
      push(DN, c + 1, 0);
      wait_until(c + 1);
      under_in = 1'b0; left_in = 1'b0; barrier_in = 1'b1;
      drain("goal");
      check("goal_done_sticky", int'(done), 1);

      // Step counter saturation over 20 forward moves
      do_reset(c);
      head_in = 1'b0; left_in = 1'b1; barrier_in = 1'b0; under_in = 1'b0;
      for (int k = 0; k < 20; k++) push(AV, c + 1 + 3 * k, exp_steps(k + 1));
      wait_until(c + 58);
      under_in = 1'b1;
      push(DN, c + 61, exp_steps(20));
      drain("saturation");
      check("steps_saturated", int'(steps), exp_steps(20));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
